uart_rx_core: RTL



---
 rtl/uart_rx_core.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 16x oversampled start/data/parity/stop with req/ack output
module uart_rx_core #(
    parameter int CLK_DIV    = 27,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] dout,
    output logic              recv_req,
    input  logic              recv_ack,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [3:0]          os_cnt_q, os_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_bit_q, par_bit_d;
    logic                stop_bit_q, stop_bit_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                recv_req_q, recv_req_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic                tick;
    logic                mid_bit;

    assign tick    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign mid_bit = tick && (os_cnt_q == 4'd15);

    // Synchroniser flops reset high so an idle line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_bit_q   <= 1'b0;
            dout_q       <= '0;
            recv_req_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_bit_q   <= stop_bit_d;
            dout_q       <= dout_d;
            recv_req_q   <= recv_req_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        os_cnt_d     = tick ? os_cnt_q + 4'd1 : os_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_bit_d   = stop_bit_q;
        dout_d       = dout_q;
        recv_req_d   = recv_req_q & ~recv_ack;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    div_cnt_d = '0;
                    os_cnt_d  = '0;
                end
            end
            START: begin
                if (tick && os_cnt_q == 4'd7) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                // Right shift: after DATA_W samples the first bit received sits in bit 0.
                if (mid_bit) begin
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_W - 1))
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    par_bit_d = rx_s_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    stop_bit_d = rx_s_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                // An ack in this same cycle frees the slot, so the new word wins over overrun.
                if (!recv_req_q || recv_ack) begin
                    dout_d       = shift_q;
                    recv_req_d   = 1'b1;
                    parity_err_d = (PARITY_EN != 0) &&
                                   ((^shift_q ^ par_bit_q) != 1'(PARITY_ODD));
                    frame_err_d  = ~stop_bit_q;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign recv_req   = recv_req_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
